sensor_copy_master: RTL and testbench
=====================================

Name: sensor_copy_master

Overview:
- AXI4 master that services the sensor controller's interrupt.
- When `sctrl_interrupt` is high, it copies the sensor's 64-word buffer into DRAM using read bursts from the sensor slave and write bursts to DRAM.
- It then issues a single-beat write to the sensor clear register and waits for the interrupt to drop.
- Sits on the CPU-side bus as an extra master beside the CPU, in the `clock` domain.

Parameters:
- SRC_BASE, 32'h1000_0000, sensor data base address (word i at SRC_BASE+4*i).
- DST_BASE, 32'h2000_0000, DRAM destination base address.
- CLR_ADDR, 32'h1000_2000, sensor clear register address; the clear write data is 32'h1.
- WORDS, 64, words per copy; must be a multiple of BURST.
- BURST, 16, beats per burst (ARLEN/AWLEN = BURST-1, at most 16).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous active-high reset
- sctrl_interrupt  input  1  sensor buffer full (level)
- copy_done  output  1  one-cycle pulse when the clear write's B response is accepted
- copy_err  output  1  sticky; set on any RRESP/BRESP != OKAY; cleared only by reset
- ARADDR  output  32  read burst address
- ARLEN  output  4  BURST-1
- ARVALID  output  1  read address valid
- ARREADY  input  1  read address ready
- RDATA  input  32  read data
- RRESP  input  2  read response
- RLAST  input  1  last read beat
- RVALID  input  1  read data valid
- RREADY  output  1  read data ready
- AWADDR  output  32  write address
- AWLEN  output  4  BURST-1 for copy bursts, 0 for the clear write
- AWVALID  output  1  write address valid
- AWREADY  input  1  write address ready
- WDATA  output  32  write data
- WSTRB  output  4  always 4'hF
- WLAST  output  1  last write beat
- WVALID  output  1  write data valid
- WREADY  input  1  write data ready
- BRESP  input  2  write response
- BVALID  input  1  write response valid
- BREADY  output  1  write response ready

Behaviour:
- ID, SIZE and BURST fields are driven at integration as constants: ID 0, SIZE 3'b010, BURST INCR.
- Reset values: all VALID/READY outputs 0, `copy_done` 0, `copy_err` 0, addresses and data 0, FSM in IDLE, burst counter 0.
- Internal storage: BURST x 32 buffer, beat pointer `bp` (4 bits), burst index `bi` counting 0..WORDS/BURST-1.
- FSM states and transitions:
  - IDLE: leave to AR when `sctrl_interrupt` = 1. Clear `bi` on entry.
  - AR: ARVALID=1, ARADDR = SRC_BASE + bi*BURST*4. ARVALID/ARADDR stay stable until ARREADY. Go to R on handshake.
  - R: RREADY=1. Each RVALID beat stores RDATA to buf[bp] and increments bp. Go to AW on the beat with RLAST; bp returns to 0.
  - AW: AWVALID=1, AWADDR = DST_BASE + bi*BURST*4, AWLEN = BURST-1. Go to W on AWREADY.
  - W: WVALID=1, WDATA = buf[bp]. bp increments on WREADY. WLAST=1 when bp = BURST-1. Go to B after the WLAST handshake.
  - B: BREADY=1. On BVALID, increment bi; if bi was the last burst go to CAW, else go to AR.
  - CAW: AWVALID=1, AWADDR = CLR_ADDR, AWLEN = 0. Go to CW on AWREADY.
  - CW: WVALID=1, WDATA = 32'h1, WLAST=1. Go to CB on WREADY.
  - CB: BREADY=1. On BVALID, pulse `copy_done` for 1 cycle and go to WAITLO.
  - WAITLO: return to IDLE when `sctrl_interrupt` = 0. This prevents a double copy while the clear propagates across the clock-domain FIFOs.
- Address and data handshake ordering:
  - AW is always completed before W is asserted; W is never issued ahead of AW.
  - Only one outstanding transaction at a time; no read/write overlap.
- Beat-count mismatch: if RLAST arrives early, the remaining buffer entries keep stale data and the write burst still sends BURST beats. If RLAST is missing on the final beat, the FSM keeps accepting beats and bp wraps mod 16. Neither case is detected.
- Error responses: RRESP/BRESP != 2'b00 sets `copy_err`; the sequence continues and is not aborted.
- `sctrl_interrupt` dropping mid-copy: ignored; the sequence completes, including the clear write.
- Reset mid-burst: outputs drop immediately at the next clock edge. No completion of the outstanding transaction is attempted; the system resets the bus together with this block.
- Latency, zero-wait slave: per burst = 1 (AR) + BURST (R) + 1 (AW) + BURST (W) + 1 (B) cycles. The full copy with default parameters is 4*35 + 3 = 143 cycles from leaving IDLE to `copy_done`.

Test Plan:
- Zero-wait slave, sensor words = index i: raise interrupt -> 4 AR bursts at 0x1000_0000 + 0x40*k. DRAM 0x2000_0000.. holds 0..63. Then one write of 1 to 0x1000_2000; `copy_done` pulses exactly once, at cycle 143.
- Random ARREADY/RVALID/AWREADY/WREADY/BVALID stalls (0-5 cycles) -> identical DRAM contents. VALID/ADDR/DATA stay stable while stalled; WLAST only on beat 15.
- Interrupt held high for 200 cycles after `copy_done` -> no second copy starts. Drop the interrupt and raise it again -> a second full copy starts.
- RRESP = 2'b10 on beat 5 of burst 2 -> `copy_err` = 1 and stays 1; copy and clear still complete; `copy_done` pulses.
- Reset asserted during the W phase of burst 1 -> the next cycle has all VALID = 0 and the FSM is in IDLE. With the interrupt still high, a fresh copy restarts at burst 0.
- Interrupt deasserted during burst 0 -> all 4 bursts and the clear write still issue.

Source files
------------

// File: rtl/sensor_copy_master.sv
// AXI4 master that copies the sensor's sample buffer into DRAM in bursts on interrupt,
// then writes the sensor clear register and waits for the interrupt to drop.
module sensor_copy_master #(
    parameter logic [31:0] SRC_BASE = 32'h1000_0000,
    parameter logic [31:0] DST_BASE = 32'h2000_0000,
    parameter logic [31:0] CLR_ADDR = 32'h1000_2000,
    parameter int unsigned WORDS    = 64,
    parameter int unsigned BURST    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sctrl_interrupt,
    output logic        copy_done,
    output logic        copy_err,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    localparam logic [3:0]  LEN         = 4'(BURST - 1);
    localparam logic [7:0]  LAST_BI     = 8'(WORDS / BURST - 1);
    localparam logic [31:0] BURST_BYTES = 32'(BURST * 4);

    typedef enum logic [3:0] {
        StIdle, StAr, StR, StAw, StW, StB, StCaw, StCw, StCb, StWaitLo
    } state_e;

    state_e      state;
    logic [31:0] data_buf [BURST];
    logic [3:0]  bp;
    logic [7:0]  bi;

    assign ARLEN = LEN;
    assign WSTRB = 4'hF;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            ARVALID   <= 1'b0;
            ARADDR    <= '0;
            RREADY    <= 1'b0;
            AWVALID   <= 1'b0;
            AWADDR    <= '0;
            AWLEN     <= '0;
            WVALID    <= 1'b0;
            WDATA     <= '0;
            WLAST     <= 1'b0;
            BREADY    <= 1'b0;
            copy_done <= 1'b0;
            copy_err  <= 1'b0;
            bp        <= '0;
            bi        <= '0;
        end else begin
            copy_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (sctrl_interrupt) begin
                        bi      <= '0;
                        bp      <= '0;
                        ARVALID <= 1'b1;
                        ARADDR  <= SRC_BASE;
                        state   <= StAr;
                    end
                end
                StAr: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= StR;
                    end
                end
                StR: begin
                    if (RVALID) begin
                        data_buf[bp] <= RDATA;
                        if (RRESP != 2'b00) copy_err <= 1'b1;
                        // An early or missing RLAST is not policed: bp simply wraps.
                        if (RLAST) begin
                            bp      <= '0;
                            RREADY  <= 1'b0;
                            AWVALID <= 1'b1;
                            AWADDR  <= DST_BASE + 32'(bi) * BURST_BYTES;
                            AWLEN   <= LEN;
                            state   <= StAw;
                        end else begin
                            bp <= bp + 4'd1;
                        end
                    end
                end
                StAw: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        WVALID  <= 1'b1;
                        WDATA   <= data_buf[0];
                        WLAST   <= (LEN == 4'd0);
                        state   <= StW;
                    end
                end
                StW: begin
                    if (WREADY) begin
                        if (WLAST) begin
                            WVALID <= 1'b0;
                            WLAST  <= 1'b0;
                            bp     <= '0;
                            BREADY <= 1'b1;
                            state  <= StB;
                        end else begin
                            bp    <= bp + 4'd1;
                            WDATA <= data_buf[bp + 4'd1];
                            WLAST <= ((bp + 4'd1) == LEN);
                        end
                    end
                end
                StB: begin
                    if (BVALID) begin
                        if (BRESP != 2'b00) copy_err <= 1'b1;
                        BREADY <= 1'b0;
                        bi     <= bi + 8'd1;
                        if (bi == LAST_BI) begin
                            AWVALID <= 1'b1;
                            AWADDR  <= CLR_ADDR;
                            AWLEN   <= 4'd0;
                            state   <= StCaw;
                        end else begin
                            ARVALID <= 1'b1;
                            ARADDR  <= SRC_BASE + 32'(bi + 8'd1) * BURST_BYTES;
                            state   <= StAr;
                        end
                    end
                end
                StCaw: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        WVALID  <= 1'b1;
                        WDATA   <= 32'h1;
                        WLAST   <= 1'b1;
                        state   <= StCw;
                    end
                end
                StCw: begin
                    if (WREADY) begin
                        WVALID <= 1'b0;
                        WLAST  <= 1'b0;
                        BREADY <= 1'b1;
                        state  <= StCb;
                    end
                end
                StCb: begin
                    if (BVALID) begin
                        if (BRESP != 2'b00) copy_err <= 1'b1;
                        BREADY    <= 1'b0;
                        copy_done <= 1'b1;
                        state     <= StWaitLo;
                    end
                end
                StWaitLo: begin
                    // Hold off until the clear has propagated, else the same buffer is copied twice.
                    if (!sctrl_interrupt) begin
                        bi    <= '0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_copy_master.sv
// Directed bench for sensor_copy_master: AXI slave/DRAM responder plus a linear test sequence.
module tb_sensor_copy_master;

    localparam logic [31:0] SRC = 32'h1000_0000;
    localparam logic [31:0] DST = 32'h2000_0000;
    localparam logic [31:0] CLR = 32'h1000_2000;

    logic        clock, reset, sctrl_interrupt, copy_done, copy_err;
    logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
    logic [3:0]  ARLEN, AWLEN, WSTRB;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, AWVALID, AWREADY;
    logic        WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [1:0]  RRESP, BRESP;

    sensor_copy_master dut (
        .clock(clock), .reset(reset), .sctrl_interrupt(sctrl_interrupt),
        .copy_done(copy_done), .copy_err(copy_err),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests = 0, fails = 0;

    // Responder state and observation counters
    logic [31:0] dram [64];
    logic [31:0] ar_q [$];
    logic [31:0] pat = 32'h0;
    logic [31:0] clr_data = 32'h0;
    logic        stall = 1'b0, err_en = 1'b0;
    int ar_cnt = 0, done_cnt = 0, clr_cnt = 0, stray = 0;
    int unstable = 0, wlast_bad = 0, order_bad = 0;

    logic [31:0] rd_addr, wr_addr, h_araddr, h_awaddr, h_wdata;
    logic [3:0]  h_arlen, h_awlen;
    logic        h_wlast;
    logic rd_act = 0, wr_act = 0, b_pend = 0;
    logic p_ar = 0, p_r = 0, p_aw = 0, p_w = 0, p_b = 0, s_ar = 0, s_aw = 0, s_w = 0;
    int rd_cnt = 0, rd_len = 16, wr_cnt = 0, wr_len = 0, r_dly = 0, b_dly = 0, widx = 0;

    function automatic int pick();
        return stall ? int'($urandom_range(0, 5)) : 0;
    endfunction

    function automatic logic rdy();
        return stall ? ($urandom_range(0, 2) == 0) : 1'b1;
    endfunction

    initial begin
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                rd_act = 0; wr_act = 0; b_pend = 0;
                p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0; s_ar = 0; s_aw = 0; s_w = 0;
                ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = 0;
                AWREADY = 0; WREADY = 0; BVALID = 0;
            end else begin
                if (s_ar && (ARVALID !== 1'b1 || ARADDR !== h_araddr)) unstable++;
                if (s_aw && (AWVALID !== 1'b1 || AWADDR !== h_awaddr || AWLEN !== h_awlen))
                    unstable++;
                if (s_w && (WVALID !== 1'b1 || WDATA !== h_wdata || WLAST !== h_wlast)) unstable++;
                if (copy_done === 1'b1) done_cnt++;
                // Book-keep the handshakes that completed on the last rising edge.
                if (p_ar) begin
                    rd_addr = h_araddr; rd_len = int'(h_arlen) + 1; rd_cnt = 0; rd_act = 1;
                    ar_cnt++; ar_q.push_back(h_araddr); r_dly = pick();
                end
                if (p_r) begin
                    rd_cnt++;
                    if (rd_cnt == rd_len) rd_act = 0;
                    r_dly = pick();
                end
                if (p_aw) begin
                    wr_addr = h_awaddr; wr_len = int'(h_awlen); wr_cnt = 0; wr_act = 1;
                end
                if (p_w) begin
                    if (h_wlast !== (wr_cnt == wr_len)) wlast_bad++;
                    if (wr_addr == CLR) begin
                        clr_cnt++; clr_data = h_wdata;
                    end else if (wr_addr >= DST && wr_addr < DST + 32'd256) begin
                        widx = int'((wr_addr - DST) >> 2) + wr_cnt;
                        if (widx < 64) dram[widx] = h_wdata; else stray++;
                    end else begin
                        stray++;
                    end
                    wr_cnt++;
                    if (h_wlast) begin
                        wr_act = 0; b_pend = 1; b_dly = pick();
                    end
                end
                if (p_b) b_pend = 0;

                ARREADY = rdy();
                AWREADY = rdy();
                WREADY  = rdy();
                if (rd_act) begin
                    if (!(RVALID && !p_r)) begin
                        if (r_dly == 0) RVALID = 1;
                        else begin RVALID = 0; r_dly--; end
                    end
                end else begin
                    RVALID = 0;
                end
                widx  = int'((rd_addr - SRC) >> 2) + rd_cnt;
                RDATA = pat + 32'(widx);
                RLAST = (rd_cnt == rd_len - 1);
                RRESP = (err_en && widx == 2 * 16 + 5) ? 2'b10 : 2'b00;
                if (b_pend) begin
                    if (!(BVALID && !p_b)) begin
                        if (b_dly == 0) BVALID = 1;
                        else begin BVALID = 0; b_dly--; end
                    end
                end else begin
                    BVALID = 0;
                end
                BRESP = 2'b00;

                if (WVALID === 1'b1 && !wr_act) order_bad++;
                if (ARVALID === 1'b1 && (wr_act || b_pend)) order_bad++;
                if (AWVALID === 1'b1 && rd_act) order_bad++;

                p_ar = ARVALID && ARREADY; p_r = RVALID && RREADY; p_aw = AWVALID && AWREADY;
                p_w  = WVALID && WREADY;   p_b = BVALID && BREADY;
                s_ar = ARVALID && !ARREADY; s_aw = AWVALID && !AWREADY; s_w = WVALID && !WREADY;
                h_araddr = ARADDR; h_arlen = ARLEN; h_awaddr = AWADDR; h_awlen = AWLEN;
                h_wdata = WDATA; h_wlast = WLAST;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (copy_done !== 1'b1 && n < budget) begin step(); n++; end
    endtask

    task automatic wait_ar(input int budget, output int n);
        n = 0;
        while (ARVALID !== 1'b1 && n < budget) begin step(); n++; end
    endtask

    function automatic int dram_bad(input logic [31:0] p);
        int bad = 0;
        for (int i = 0; i < 64; i++) if (dram[i] !== p + 32'(i)) bad++;
        return bad;
    endfunction

    task automatic clear_dram();
        for (int i = 0; i < 64; i++) dram[i] = 32'hDEAD_BEEF;
    endtask

    task automatic post_copy(input string pfx, input int d0, input int c0, input int a0);
        repeat (3) step();
        check({pfx, "_done_once"}, 32'(done_cnt - d0), 1);
        check({pfx, "_clear_once"}, 32'(clr_cnt - c0), 1);
        check({pfx, "_clear_data"}, clr_data, 32'h1);
        check({pfx, "_ar_bursts"}, 32'(ar_cnt - a0), 4);
        check({pfx, "_dram"}, 32'(dram_bad(pat)), 0);
    endtask

    int n, d0, c0, a0;

    initial begin
        reset = 1'b1;
        sctrl_interrupt = 1'b0;
        repeat (3) step();
        check("reset_valids", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 0);
        check("reset_flags", 32'({copy_done, copy_err}), 0);
        check("reset_araddr", ARADDR, 0);
        check("reset_awaddr", AWADDR, 0);
        check("reset_wdata", WDATA, 0);
        reset = 1'b0;
        repeat (2) step();

        // Zero-wait copy of words 0..63, with exact latency
        clear_dram(); pat = 32'h0; ar_q.delete();
        d0 = done_cnt; c0 = clr_cnt; a0 = ar_cnt;
        sctrl_interrupt = 1'b1;
        wait_ar(20, n);
        check("t1_ar_seen", 32'(ARVALID), 1);
        check("t1_arlen", 32'(ARLEN), 32'hF);
        wait_done(1000, n);
        check("t1_latency", 32'(n), 143);
        post_copy("t1", d0, c0, a0);
        for (int k = 0; k < 4; k++)
            check("t1_ar_addr", (k < ar_q.size()) ? ar_q[k] : 32'hFFFF_FFFF, SRC + 32'(k * 64));
        check("t1_no_err", 32'(copy_err), 0);

        // Interrupt left high: no re-copy
        d0 = done_cnt; a0 = ar_cnt;
        repeat (200) step();
        check("t2_no_redone", 32'(done_cnt - d0), 0);
        check("t2_no_reread", 32'(ar_cnt - a0), 0);

        // Drop and re-raise with random stalls
        sctrl_interrupt = 1'b0;
        repeat (3) step();
        clear_dram(); pat = 32'h100; stall = 1'b1;
        d0 = done_cnt; c0 = clr_cnt; a0 = ar_cnt;
        sctrl_interrupt = 1'b1;
        wait_done(5000, n);
        check("t3_done_in_budget", 32'(n < 5000), 1);
        sctrl_interrupt = 1'b0;
        post_copy("t3", d0, c0, a0);
        stall = 1'b0;

        // Read error on burst 2 beat 5
        clear_dram(); pat = 32'h200; err_en = 1'b1;
        d0 = done_cnt; c0 = clr_cnt; a0 = ar_cnt;
        sctrl_interrupt = 1'b1;
        wait_done(1000, n);
        check("t4_done_in_budget", 32'(n < 1000), 1);
        sctrl_interrupt = 1'b0;
        err_en = 1'b0;
        post_copy("t4", d0, c0, a0);
        check("t4_err_set", 32'(copy_err), 1);

        // Interrupt dropped during burst 0
        repeat (2) step();
        clear_dram(); pat = 32'h300;
        d0 = done_cnt; c0 = clr_cnt; a0 = ar_cnt;
        sctrl_interrupt = 1'b1;
        wait_ar(20, n);
        repeat (5) step();
        sctrl_interrupt = 1'b0;
        wait_done(1000, n);
        check("t5_done_in_budget", 32'(n < 1000), 1);
        post_copy("t5", d0, c0, a0);
        check("t5_err_sticky", 32'(copy_err), 1);

        // Reset during the W phase of burst 1, then restart from burst 0
        clear_dram(); pat = 32'h400;
        sctrl_interrupt = 1'b1;
        n = 0;
        while (!(WVALID === 1'b1 && AWADDR === DST + 32'h40) && n < 500) begin step(); n++; end
        check("t6_reached_w1", 32'(n < 500), 1);
        reset = 1'b1;
        step();
        check("t6_valids_low", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 0);
        check("t6_err_cleared", 32'(copy_err), 0);
        reset = 1'b0;
        ar_q.delete();
        d0 = done_cnt; c0 = clr_cnt; a0 = ar_cnt;
        step();
        check("t6_restart_arvalid", 32'(ARVALID), 1);
        check("t6_restart_araddr", ARADDR, SRC);
        wait_done(1000, n);
        check("t6_done_in_budget", 32'(n < 1000), 1);
        sctrl_interrupt = 1'b0;
        post_copy("t6", d0, c0, a0);

        check("payload_stable", 32'(unstable), 0);
        check("wlast_placement", 32'(wlast_bad), 0);
        check("channel_order", 32'(order_bad), 0);
        check("stray_writes", 32'(stray), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
